wb_sram_ctrl: RTL and testbench

- Parametrised Wishbone classic slave controller for the single-port SRAM macro. Successor to the fixed 32-bit, 256-word, zero-wait adapter.
- Adds configurable width, depth and macro read latency.
- Adds proper ack timing, out-of-range error response, and per-byte writes through read-modify-write, because the macro has no write mask.
- Sits between the Wishbone interconnect slave port and one SRAM macro instance.

---
 rtl/wb_sram_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone classic slave in front of one single-port SRAM macro.
// Provides configurable width/depth/read latency, out-of-range error response
// and byte-granular writes through read-modify-write (the macro has no mask).
// Optional feature: define WB_SRAM_PARITY_EN to store one even-parity bit per
// byte next to each word and report parity mismatches with s_err.
module wb_sram_ctrl #(
    parameter int DW       = 32,
    parameter int AW       = 8,
    parameter int DEPTH    = 256,
    parameter int ADDR_LSB = 2,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_cyc,
    input  logic                s_stb,
    input  logic                s_we,
    input  logic [DW/8-1:0]     s_sel,
    input  logic [31:0]         s_adr,
    input  logic [DW-1:0]       s_wdata,
    output logic [DW-1:0]       s_rdata,
    output logic                s_ack,
    output logic                s_err,
    output logic                mem_csb,
    output logic                mem_web,
    output logic [AW-1:0]       mem_addr,
`ifdef WB_SRAM_PARITY_EN
    output logic [DW+DW/8-1:0]  mem_din,
    input  logic [DW+DW/8-1:0]  mem_dout
`else
    output logic [DW-1:0]       mem_din,
    input  logic [DW-1:0]       mem_dout
`endif
);
    localparam int NB = DW / 8;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int HI = ADDR_LSB + AW;
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);
    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RMW_WAIT = 3'd2,
        ACK      = 3'd3,
        ERR      = 3'd4
    } state_t;

    // Byte i of the result comes from new_d when sel[i] is set, else from old_d.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_d,
                                                  input logic [DW-1:0] new_d,
                                                  input logic [NB-1:0] sel);
        logic [DW-1:0] res;
        res = old_d;
        for (int i = 0; i < NB; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_d[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_d[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef WB_SRAM_PARITY_EN
    // Even parity per byte: bit i makes byte i plus its parity bit even.
    function automatic logic [NB-1:0] byte_parity(input logic [DW-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q;
    logic [DW-1:0]   wdata_q;
    logic [NB-1:0]   sel_q;
    logic [DW-1:0]   rdata_q;
    logic            ack_q;
    logic            err_q;

    logic            req_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     adr_hi_s;
    logic            oor_s;
    logic            par_ok_s;
    logic            cap_s;
    logic [DW-1:0]   wr_data_s;

    // A request is only honoured outside reset so no command leaks while rst_n is low.
    assign req_s    = rst_n & s_cyc & s_stb;
    assign idx_s    = s_adr[HI-1:ADDR_LSB];
    assign adr_hi_s = s_adr >> HI;
    assign oor_s    = (adr_hi_s != 32'd0) || (32'(idx_s) >= DEPTH_W);

`ifdef WB_SRAM_PARITY_EN
    assign par_ok_s = (byte_parity(mem_dout[DW-1:0]) == mem_dout[DW +: NB]);
    assign mem_din  = {byte_parity(wr_data_s), wr_data_s};
`else
    assign par_ok_s = 1'b1;
    assign mem_din  = wr_data_s;
`endif

    assign s_rdata = rdata_q;
    assign s_ack   = ack_q;
    assign s_err   = err_q;

    // Next-state decode plus the macro command issued in the current cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_s     = 1'b0;
        mem_csb   = 1'b1;
        mem_web   = 1'b1;
        mem_addr  = {AW{1'b0}};
        wr_data_s = {DW{1'b0}};
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (oor_s) begin
                        state_d = ERR;
                    end else if (s_we && (s_sel == {NB{1'b0}})) begin
                        state_d = ACK;
                    end else if (s_we && (&s_sel)) begin
                        mem_csb   = 1'b0;
                        mem_web   = 1'b0;
                        mem_addr  = idx_s;
                        wr_data_s = s_wdata;
                        state_d   = ACK;
                    end else begin
                        // Plain read, or the read half of a partial write.
                        mem_csb  = 1'b0;
                        mem_addr = idx_s;
                        cnt_d    = {CW{1'b0}};
                        state_d  = s_we ? RMW_WAIT : RD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (!s_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cap_s   = 1'b1;
                    state_d = par_ok_s ? ACK : ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RMW_WAIT: begin
                if (!s_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    if (par_ok_s) begin
                        mem_csb   = 1'b0;
                        mem_web   = 1'b0;
                        mem_addr  = idx_q;
                        wr_data_s = merge_bytes(mem_dout[DW-1:0], wdata_q, sel_q);
                        state_d   = ACK;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request fields and the registered bus response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            idx_q   <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
            sel_q   <= {NB{1'b0}};
            rdata_q <= {DW{1'b0}};
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == ACK);
            err_q   <= (state_d == ERR);
            if (cap_s) begin
                rdata_q <= mem_dout[DW-1:0];
            end
            if ((state_q == IDLE) && req_s) begin
                idx_q   <= idx_s;
                wdata_q <= s_wdata;
                sel_q   <= s_sel;
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb_wb_sram_ctrl: randomized + directed bench for wb_sram_ctrl with an SRAM
// macro model and a word-level reference memory.
module tb_wb_sram_ctrl;
    localparam int DW       = 32;
    localparam int AW       = 8;
    localparam int DEPTH    = 200;
    localparam int ADDR_LSB = 2;
    localparam int RD_LAT   = 2;
    localparam int NB       = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_cyc, s_stb, s_we;
    logic [NB-1:0]   s_sel;
    logic [31:0]     s_adr;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata;
    logic            s_ack, s_err;
    logic            mem_csb, mem_web;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_sram_ctrl #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .ADDR_LSB(ADDR_LSB), .RD_LAT(RD_LAT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_ack(s_ack), .s_err(s_err),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // SRAM macro model: command sampled at the edge, read data valid RD_LAT cycles later.
    logic [DW-1:0] macro_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe   [0:RD_LAT-1];
    int n_mrd = 0;
    int n_mwr = 0;
    assign mem_dout = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (!mem_csb && !mem_web) begin
            macro_mem[mem_addr] <= mem_din;
            n_mwr <= n_mwr + 1;
        end
        if (!mem_csb && mem_web) begin
            rd_pipe[0] <= macro_mem[mem_addr];
            n_mrd <= n_mrd + 1;
        end else begin
            rd_pipe[0] <= $urandom;
        end
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] last_rdata;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One bus transaction, expectations derived from the word-level rules.
    task automatic do_txn(input logic we, input logic [31:0] adr,
                          input logic [NB-1:0] sel, input logic [DW-1:0] wd);
        int widx, exp_lat, exp_rd, exp_wr, rd0, wr0, lat;
        logic exp_err;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] nv;
        widx     = int'(adr >> ADDR_LSB);
        exp_err  = 1'b0;
        exp_rd   = 0;
        exp_wr   = 0;
        exp_lat  = 1;
        exp_data = last_rdata;
        if (widx >= DEPTH) begin
            exp_err = 1'b1;
        end else if (we) begin
            if (sel == {NB{1'b1}}) begin
                exp_wr = 1;
                ref_mem[widx] = wd;
            end else if (sel != {NB{1'b0}}) begin
                exp_rd  = 1;
                exp_wr  = 1;
                exp_lat = RD_LAT + 1;
                nv = ref_mem[widx];
                for (int b = 0; b < NB; b++) if (sel[b]) nv[8*b +: 8] = wd[8*b +: 8];
                ref_mem[widx] = nv;
            end
        end else begin
            exp_rd     = 1;
            exp_lat    = RD_LAT + 1;
            exp_data   = ref_mem[widx];
            last_rdata = exp_data;
        end

        @(negedge clk);
        rd0 = n_mrd;
        wr0 = n_mwr;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_sel = sel; s_adr = adr; s_wdata = wd;
        for (lat = 1; lat <= 16; lat++) begin
            @(negedge clk);
            if (s_ack || s_err) break;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("ack", s_ack, !exp_err);
        check_eq("err", s_err, exp_err);
        check_eq("rdata", s_rdata, exp_data);
        check_eq("macro_reads", n_mrd - rd0, exp_rd);
        check_eq("macro_writes", n_mwr - wr0, exp_wr);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen, wr0, r, sw;
        logic [31:0] adr;
        logic [NB-1:0] sel;
        logic [DW-1:0] wd;

        rst_n = 1'b0;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_sel = {NB{1'b0}}; s_adr = 32'd0; s_wdata = {DW{1'b0}};
        last_rdata = {DW{1'b0}};
        repeat (3) @(negedge clk);
        check_eq("rst_ack", s_ack, 1'b0);
        check_eq("rst_err", s_err, 1'b0);
        check_eq("rst_rdata", s_rdata, 32'd0);
        check_eq("rst_csb", mem_csb, 1'b1);
        check_eq("rst_web", mem_web, 1'b1);
        check_eq("rst_addr", mem_addr, 8'd0);
        check_eq("rst_din", mem_din, 32'd0);
        rst_n = 1'b1;

        // Fill every implemented word through the bus.
        for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 32'(i * 4), {NB{1'b1}}, $urandom);

        // Full write then read back.
        do_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        do_txn(1'b0, 32'h10, 4'h0, 32'h0);
        // Partial write via read-modify-write.
        do_txn(1'b1, 32'h20, 4'hF, 32'h11223344);
        do_txn(1'b1, 32'h20, 4'h5, 32'hAABBCCDD);
        do_txn(1'b0, 32'h20, 4'h0, 32'h0);
        // Range boundaries and empty write.
        do_txn(1'b0, 32'h400, 4'h0, 32'h0);
        do_txn(1'b0, 32'h320, 4'h0, 32'h0);
        do_txn(1'b0, 32'h31C, 4'h0, 32'h0);
        do_txn(1'b1, 32'h30, 4'h0, 32'h12345678);
        do_txn(1'b0, 32'h30, 4'h0, 32'h0);

        // Abort a partial write one cycle after the request.
        @(negedge clk);
        wr0 = n_mwr;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_sel = 4'h3; s_adr = 32'h24; s_wdata = $urandom;
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_ack || s_err) seen = 1;
        end
        check_eq("abort_resp", seen, 0);
        check_eq("abort_writes", n_mwr - wr0, 0);
        do_txn(1'b0, 32'h24, 4'h0, 32'h0);

        // Strobe held through the ack cycle must not start a second write.
        wd = 32'hCAFEF00D;
        @(negedge clk);
        wr0 = n_mwr;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_sel = 4'hF; s_adr = 32'h28; s_wdata = wd;
        @(negedge clk);
        check_eq("held_ack1", s_ack, 1'b1);
        @(negedge clk);
        check_eq("held_ack2", s_ack, 1'b0);
        check_eq("held_err2", s_err, 1'b0);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        @(negedge clk);
        check_eq("held_ack3", s_ack, 1'b0);
        check_eq("held_writes", n_mwr - wr0, 1);
        ref_mem[10] = wd;
        do_txn(1'b0, 32'h28, 4'h0, 32'h0);

        // Reset pulsed in the middle of a read, request still on the bus.
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h10;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ack", s_ack, 1'b0);
        check_eq("midrst_err", s_err, 1'b0);
        check_eq("midrst_csb", mem_csb, 1'b1);
        check_eq("midrst_rdata", s_rdata, 32'd0);
        s_cyc = 1'b0; s_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = {DW{1'b0}};
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_ack || s_err) seen = 1;
        end
        check_eq("midrst_late_resp", seen, 0);
        do_txn(1'b0, 32'h10, 4'h0, 32'h0);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) adr = ($urandom | 32'h400);
            else adr = 32'($urandom_range(0, DEPTH + 10) * 4 + $urandom_range(0, 3));
            sw = int'($urandom_range(0, 3));
            if (sw == 0) sel = {NB{1'b0}};
            else if (sw == 1) sel = {NB{1'b1}};
            else sel = NB'($urandom);
            do_txn(1'($urandom_range(0, 1)), adr, sel, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
